// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run controller for NUM_CORES processor cores. A run works like this:
//   1. Hold every core in reset for RST_CYCLES cycles.
//   2. Enable execution.
//   3. Finish in DONE once every core has signalled halt, or in TIMEOUT once
//      MAX_CYCLES enabled cycles have passed without that.
// All outputs are registered.
//
// Optional feature (macro CPU_RUN_CTRL_STEP_EN):
//   Adds the inputs step_mode and step. In RUN with step_mode=1, core_en is
//   high for exactly one cycle after each cycle in which step=1.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   begin a run (honoured in IDLE/DONE/TIMEOUT)
//   abort        in   cancel a run (honoured in RESET/RUN)
//   halt         in   per-core halt indication, sampled on enabled cycles
//   step_mode    in   (CPU_RUN_CTRL_STEP_EN only) single-step mode select
//   step         in   (CPU_RUN_CTRL_STEP_EN only) request one enabled cycle
//   core_reset   out  per-core reset, active-high
//   core_en      out  execution enable shared by all cores
//   running      out  high in RESET and RUN
//   done         out  all cores halted within budget (sticky until start)
//   timeout      out  budget exhausted first (sticky until start)
//   cycle_count  out  enabled cycles in current/last run
//   halted_mask  out  sticky per-core halt record
//   dbg_state    out  current FSM state, for observation
//
// Handshake: start and abort are level-sampled single-cycle requests. No
// ready is returned; a request made in a state that ignores it is dropped.
// ----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int NUM_CORES  = 1,
    parameter int RST_CYCLES = 1,
    parameter int MAX_CYCLES = 20,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_CORES-1:0] halt,
`ifdef CPU_RUN_CTRL_STEP_EN
    input  logic                 step_mode,
    input  logic                 step,
`endif
    output logic [NUM_CORES-1:0] core_reset,
    output logic                 core_en,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic [2:0]           dbg_state
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);
    localparam logic [RW-1:0]    RST_LD  = RW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [RW-1:0]          rst_cnt, rst_cnt_n;
    logic [NUM_CORES-1:0]   core_reset_n;
    logic                   core_en_n, running_n, done_n, timeout_n;
    logic [CNT_W-1:0]       cycle_count_n;
    logic [NUM_CORES-1:0]   halted_mask_n;
    logic [CNT_W-1:0]       cnt_inc;
    logic [NUM_CORES-1:0]   mask_upd;
    logic                   run_en;

    // Value core_en takes for the next cycle while the run continues.
`ifdef CPU_RUN_CTRL_STEP_EN
    assign run_en = step_mode ? step : 1'b1;
`else
    assign run_en = 1'b1;
`endif

    assign dbg_state = state;
    assign cnt_inc   = cycle_count + 1'b1;
    assign mask_upd  = halted_mask | halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            core_reset  <= '1;
            core_en     <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            halted_mask <= '0;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            core_reset  <= core_reset_n;
            core_en     <= core_en_n;
            running     <= running_n;
            done        <= done_n;
            timeout     <= timeout_n;
            cycle_count <= cycle_count_n;
            halted_mask <= halted_mask_n;
        end
    end

    always_comb begin
        state_n       = state;
        rst_cnt_n     = rst_cnt;
        core_reset_n  = core_reset;
        core_en_n     = core_en;
        running_n     = running;
        done_n        = done;
        timeout_n     = timeout;
        cycle_count_n = cycle_count;
        halted_mask_n = halted_mask;

        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                // start beats abort here; abort has no meaning outside a run.
                if (start) begin
                    state_n       = S_RESET;
                    rst_cnt_n     = RST_LD;
                    core_reset_n  = '1;
                    core_en_n     = 1'b0;
                    running_n     = 1'b1;
                    done_n        = 1'b0;
                    timeout_n     = 1'b0;
                    cycle_count_n = '0;
                    halted_mask_n = '0;
                end
            end

            S_RESET: begin
                if (abort) begin
                    state_n      = S_IDLE;
                    core_reset_n = '1;
                    core_en_n    = 1'b0;
                    running_n    = 1'b0;
                end else if (rst_cnt == '0) begin
                    state_n      = S_RUN;
                    core_reset_n = '0;
                    core_en_n    = run_en;
                end else begin
                    rst_cnt_n = rst_cnt - 1'b1;
                end
            end

            S_RUN: begin
                // An enabled cycle is always accounted for, including one that
                // ends in an abort, because the cores really executed it.
                if (core_en) begin
                    cycle_count_n = cnt_inc;
                    halted_mask_n = mask_upd;
                end
                if (abort) begin
                    state_n      = S_IDLE;
                    core_reset_n = '1;
                    core_en_n    = 1'b0;
                    running_n    = 1'b0;
                end else if (core_en && (&mask_upd)) begin
                    // Cores stay out of reset so their state can be inspected.
                    state_n   = S_DONE;
                    core_en_n = 1'b0;
                    running_n = 1'b0;
                    done_n    = 1'b1;
                end else if (core_en && (cnt_inc == MAX_C)) begin
                    state_n   = S_TIMEOUT;
                    core_en_n = 1'b0;
                    running_n = 1'b0;
                    timeout_n = 1'b1;
                end else begin
                    core_en_n = run_en;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Directed bench with two controllers sharing clk/reset/start/abort:
//   dut1  NUM_CORES=1, RST_CYCLES=1, MAX_CYCLES=20
//   dut2  NUM_CORES=2, RST_CYCLES=3, MAX_CYCLES=20
// Each scenario task drives its own stimulus and checks its results against
// hand-computed values. Inputs change 1 ns after a rising edge, and outputs
// are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic        halt1;
    logic [1:0]  halt2;
    logic        step_mode, step;

    logic        core_reset1, core_en1, running1, done1, timeout1, mask1;
    logic [15:0] cnt1;
    logic [2:0]  st1;
    logic [1:0]  core_reset2, mask2;
    logic        core_en2, running2, done2, timeout2;
    logic [15:0] cnt2;
    logic [2:0]  st2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.NUM_CORES(1), .RST_CYCLES(1), .MAX_CYCLES(20), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .halt(halt1),
`ifdef CPU_RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .core_reset(core_reset1), .core_en(core_en1), .running(running1),
        .done(done1), .timeout(timeout1), .cycle_count(cnt1),
        .halted_mask(mask1), .dbg_state(st1)
    );

    cpu_run_ctrl #(.NUM_CORES(2), .RST_CYCLES(3), .MAX_CYCLES(20), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .halt(halt2),
`ifdef CPU_RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .core_reset(core_reset2), .core_en(core_en2), .running(running2),
        .done(done2), .timeout(timeout2), .cycle_count(cnt2),
        .halted_mask(mask2), .dbg_state(st2)
    );

    // Advance past one rising edge: outputs are stable and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        halt1 = 1'b0; halt2 = 2'b00; step_mode = 1'b0; step = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // start pulse, then one more edge for dut1 (RST_CYCLES=1) to enter RUN.
    task automatic start_dut1();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (core_reset1 !== 1'b1 || core_en1 !== 1'b0 || running1 !== 1'b0 ||
            done1 !== 1'b0 || timeout1 !== 1'b0 || cnt1 !== 16'd0 ||
            mask1 !== 1'b0 || st1 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: rst=%b en=%b run=%b done=%b to=%b cnt=%0d mask=%b st=%0d, want 1 0 0 0 0 0 0 0",
                     core_reset1, core_en1, running1, done1, timeout1, cnt1, mask1, st1);
        end
        n_checks++;
        if (core_reset2 !== 2'b11 || core_en2 !== 1'b0 || cnt2 !== 16'd0 || mask2 !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_dut2: rst=%b en=%b cnt=%0d mask=%b, want 11 0 0 00",
                     core_reset2, core_en2, cnt2, mask2);
        end
    endtask

    task automatic test_done();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (running1 !== 1'b1 || core_reset1 !== 1'b1 || core_en1 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_resetphase: run=%b rst=%b en=%b, want 1 1 0", running1, core_reset1, core_en1);
        end
        tick();
        n_checks++;
        if (core_reset1 !== 1'b0 || core_en1 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_enable: rst=%b en=%b, want 0 1", core_reset1, core_en1);
        end
        for (int k = 1; k <= 5; k++) begin
            halt1 = (k == 5);
            tick();
            if (k == 4) begin
                n_checks++;
                if (cnt1 !== 16'd4 || core_en1 !== 1'b1 || done1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_cycle4: cnt=%0d en=%b done=%b, want 4 1 0", cnt1, core_en1, done1);
                end
            end
        end
        halt1 = 1'b0;
        n_checks++;
        if (done1 !== 1'b1 || timeout1 !== 1'b0 || cnt1 !== 16'd5 || core_en1 !== 1'b0 ||
            running1 !== 1'b0 || core_reset1 !== 1'b0 || mask1 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_final: done=%b to=%b cnt=%0d en=%b run=%b rst=%b mask=%b, want 1 0 5 0 0 0 1",
                     done1, timeout1, cnt1, core_en1, running1, core_reset1, mask1);
        end
        tick();
        n_checks++;
        if (done1 !== 1'b1 || cnt1 !== 16'd5) begin
            n_fail++;
            $display("FAIL done_sticky: done=%b cnt=%0d, want 1 5", done1, cnt1);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_dut1();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 19) begin
                n_checks++;
                if (cnt1 !== 16'd19 || core_en1 !== 1'b1 || timeout1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_cycle19: cnt=%0d en=%b to=%b, want 19 1 0", cnt1, core_en1, timeout1);
                end
            end
        end
        n_checks++;
        if (timeout1 !== 1'b1 || done1 !== 1'b0 || cnt1 !== 16'd20 || mask1 !== 1'b0 ||
            core_en1 !== 1'b0 || running1 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_final: to=%b done=%b cnt=%0d mask=%b en=%b run=%b, want 1 0 20 0 0 0",
                     timeout1, done1, cnt1, mask1, core_en1, running1);
        end
        tick();
        tick();
        n_checks++;
        if (cnt1 !== 16'd20 || timeout1 !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_hold: cnt=%0d to=%b, want 20 1", cnt1, timeout1);
        end
    endtask

    task automatic test_two_cores();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (core_reset2 !== 2'b11 || core_en2 !== 1'b0 || running2 !== 1'b1) begin
            n_fail++;
            $display("FAIL two_resetphase: rst=%b en=%b run=%b, want 11 0 1", core_reset2, core_en2, running2);
        end
        tick();
        n_checks++;
        if (core_reset2 !== 2'b00 || core_en2 !== 1'b1) begin
            n_fail++;
            $display("FAIL two_enable: rst=%b en=%b, want 00 1", core_reset2, core_en2);
        end
        for (int k = 1; k <= 9; k++) begin
            halt2 = {k == 9, k == 4};
            tick();
            if (k == 4) begin
                n_checks++;
                if (mask2 !== 2'b01 || done2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL two_mask01: mask=%b done=%b, want 01 0", mask2, done2);
                end
            end
        end
        halt2 = 2'b00;
        n_checks++;
        if (mask2 !== 2'b11 || done2 !== 1'b1 || cnt2 !== 16'd9 || timeout2 !== 1'b0 || core_en2 !== 1'b0) begin
            n_fail++;
            $display("FAIL two_final: mask=%b done=%b cnt=%0d to=%b en=%b, want 11 1 9 0 0",
                     mask2, done2, cnt2, timeout2, core_en2);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_dut1();
        for (int k = 1; k <= 20; k++) begin
            halt1 = (k == 20);
            tick();
        end
        halt1 = 1'b0;
        n_checks++;
        if (done1 !== 1'b1 || timeout1 !== 1'b0 || cnt1 !== 16'd20) begin
            n_fail++;
            $display("FAIL simul_done_wins: done=%b to=%b cnt=%0d, want 1 0 20", done1, timeout1, cnt1);
        end
    endtask

    task automatic test_abort_restart();
        do_reset();
        start_dut1();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (st1 !== 3'd0 || core_reset1 !== 1'b1 || core_en1 !== 1'b0 || running1 !== 1'b0 ||
            cnt1 !== 16'd3 || done1 !== 1'b0 || timeout1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: st=%0d rst=%b en=%b run=%b cnt=%0d done=%b to=%b, want 0 1 0 0 3 0 0",
                     st1, core_reset1, core_en1, running1, cnt1, done1, timeout1);
        end
        tick();
        n_checks++;
        if (cnt1 !== 16'd3 || st1 !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_hold: cnt=%0d st=%0d, want 3 0", cnt1, st1);
        end
        // start and abort together in IDLE: start wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (running1 !== 1'b1 || cnt1 !== 16'd0 || core_reset1 !== 1'b1 || st1 !== 3'd1) begin
            n_fail++;
            $display("FAIL restart_reset: run=%b cnt=%0d rst=%b st=%0d, want 1 0 1 1",
                     running1, cnt1, core_reset1, st1);
        end
        tick();
        n_checks++;
        if (core_en1 !== 1'b1 || core_reset1 !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_run: en=%b rst=%b, want 1 0", core_en1, core_reset1);
        end
        // start while running is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (cnt1 !== 16'd1 || core_en1 !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored: cnt=%0d en=%b, want 1 1", cnt1, core_en1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        start_dut1();
        tick();
        tick();
        halt1 = 1'b1;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        halt1 = 1'b0;
        n_checks++;
        if (core_reset1 !== 1'b1 || core_en1 !== 1'b0 || running1 !== 1'b0 || done1 !== 1'b0 ||
            timeout1 !== 1'b0 || cnt1 !== 16'd0 || mask1 !== 1'b0 || st1 !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset: rst=%b en=%b run=%b done=%b to=%b cnt=%0d mask=%b st=%0d, want 1 0 0 0 0 0 0 0",
                     core_reset1, core_en1, running1, done1, timeout1, cnt1, mask1, st1);
        end
    endtask

`ifdef CPU_RUN_CTRL_STEP_EN
    task automatic test_step();
        do_reset();
        step_mode = 1'b1;
        start_dut1();
        n_checks++;
        if (core_en1 !== 1'b0 || core_reset1 !== 1'b0 || st1 !== 3'd2) begin
            n_fail++;
            $display("FAIL step_idle_run: en=%b rst=%b st=%0d, want 0 0 2", core_en1, core_reset1, st1);
        end
        for (int p = 0; p < 4; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            n_checks++;
            if (core_en1 !== 1'b1) begin
                n_fail++;
                $display("FAIL step_pulse_high: pulse=%0d en=%b, want 1", p, core_en1);
            end
            tick();
            n_checks++;
            if (core_en1 !== 1'b0 || cnt1 !== 16'(p + 1)) begin
                n_fail++;
                $display("FAIL step_pulse_low: pulse=%0d en=%b cnt=%0d, want 0 %0d", p, core_en1, cnt1, p + 1);
            end
            tick();
        end
        n_checks++;
        if (cnt1 !== 16'd4 || timeout1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL step_final: cnt=%0d to=%b done=%b, want 4 0 0", cnt1, timeout1, done1);
        end
        step_mode = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        halt1 = 1'b0; halt2 = 2'b00; step_mode = 1'b0; step = 1'b0;
        tick();
        test_reset();
        test_done();
        test_timeout();
        test_two_cores();
        test_simultaneous();
        test_abort_restart();
        test_mid_reset();
`ifdef CPU_RUN_CTRL_STEP_EN
        test_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for one or more processor cores. It sequences each core's reset, enables execution for a bounded number of cycles, and reports completion when every core signals halt, or a timeout if the cycle budget runs out. It sits between the system clock/reset and the `cpu` instances, and replaces free-running reset/stop sequencing with a synthesizable, observable controller.

## Interface
Parameters:
- `NUM_CORES`, 1: number of controlled cores (1..8).
- `RST_CYCLES`, 1: cycles `core_reset` is held after `start` (≥1).
- `MAX_CYCLES`, 20: enabled-cycle budget before timeout (≥1, < 2^CNT_W).
- `CNT_W`, 16: width of the cycle counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE, DONE, TIMEOUT.
- `abort`  in  1  cancel a run in RESET or RUN.
- `halt`  in  NUM_CORES  per-core halt indication, sampled in RUN.
- `core_reset`  out  NUM_CORES  reset to each core, active-high.
- `core_en`  out  1  execution enable to all cores.
- `running`  out  1  high in RESET and RUN states.
- `done`  out  1  all cores halted within budget (sticky).
- `timeout`  out  1  budget exhausted before all halted (sticky).
- `cycle_count`  out  CNT_W  enabled cycles in current/last run.
- `halted_mask`  out  NUM_CORES  sticky per-core halt record.

## Operation
- States: IDLE, RESET, RUN, DONE, TIMEOUT. All outputs are registered.
- After `reset`: IDLE; `core_reset`=all ones, `core_en`=0, `running`=0, `done`=0, `timeout`=0, `cycle_count`=0, `halted_mask`=0.
- IDLE/DONE/TIMEOUT + `start` → RESET: `cycle_count` and `halted_mask` are cleared; `done`/`timeout` are cleared; `core_reset`=all ones; an internal reset counter is loaded.
- RESET → RUN after RST_CYCLES cycles in RESET: `core_reset`=0, `core_en`=1.
- RUN, each cycle with `core_en`=1: `cycle_count`+1; `halted_mask` |= `halt`.
- RUN → DONE when (`halted_mask` | `halt`) is all ones. `core_en`=0, `done`=1, `core_reset` stays 0 (cores keep their state for inspection).
- RUN → TIMEOUT when the enabled cycle brings `cycle_count` to MAX_CYCLES and the completion condition is false. `core_en`=0, `timeout`=1.
- Simultaneous completion and budget exhaustion: DONE wins.
- `abort` in RESET or RUN → IDLE: `core_reset`=all ones, `core_en`=0; `cycle_count`/`halted_mask` are held for readout. `abort` has priority over completion or timeout in the same cycle. `abort` is ignored elsewhere.
- `start` in RESET or RUN is ignored. `start` and `abort` together in IDLE: `start` wins.
- `reset` mid-run: all state returns to reset values on the next edge, regardless of other inputs.
- `cycle_count` never exceeds MAX_CYCLES. `halted_mask` bits never clear except on `start` or `reset`.

## Timing
- `start` high at edge t (IDLE) → `running`=1 after t. `core_reset` deasserts and `core_en` asserts after edge t+RST_CYCLES.
- Enabled cycles are exactly the cycles between the `core_en` rise and fall. Timeout occurs after exactly MAX_CYCLES enabled cycles.
- `halt` sampled at edge e → `done` and `core_en`=0 after edge e. The halting cycle is counted.
- `running` falls on the same edge that `done`, `timeout`, or the abort is registered.

## Configuration
- `CPU_RUN_CTRL_STEP_EN` defined: adds input ports `step_mode` (1) and `step` (1).
  - In RUN with `step_mode`=1, `core_en` is high for one cycle after each cycle in which `step`=1, and low otherwise.
  - `cycle_count` and the timeout budget count only enabled cycles.
  - Completion and timeout are evaluated only on enabled cycles.
- Not defined: no such ports exist; `core_en` is continuously high in RUN.

## Test plan
- NUM_CORES=1, RST_CYCLES=1, MAX_CYCLES=20; `start` pulse; `halt`=1 on the 5th enabled cycle → `core_reset` low 1 cycle after `start`, `done`=1, `cycle_count`=5, `timeout`=0.
- Same configuration, `halt` never asserted → `timeout`=1 after exactly 20 `core_en` cycles, `cycle_count`=20, `halted_mask`=0.
- NUM_CORES=2, RST_CYCLES=3: `halt[0]` on cycle 4, `halt[1]` on cycle 9 → `halted_mask`=01 then 11, `done` after cycle 9, `cycle_count`=9.
- MAX_CYCLES=20, all `halt` bits first asserted on enabled cycle 20 → `done`=1, `timeout`=0, `cycle_count`=20.
- `abort` on enabled cycle 3, then `start` → IDLE with `core_reset`=1 and `cycle_count`=3; restart clears the counter to 0 and re-runs the reset phase. Also check: `reset` asserted mid-RUN → all outputs at reset values one edge later.
- With `CPU_RUN_CTRL_STEP_EN`, `step_mode`=1, 4 `step` pulses spaced 3 cycles apart → 4 single-cycle `core_en` pulses, `cycle_count`=4.
